gpio_in_debounce: RTL

- Input-conditioning stage directly upstream of the APB GPIO slave.
- Synchronises raw asynchronous pad inputs into the pclk domain and applies a per-pin glitch/debounce filter.
- Emits clean levels (drive the GPIO slave's gpio_in) plus one-cycle rise/fall pulses for event logic.
- Debounce threshold and filter enable are static configuration inputs, driven from a config register.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_debounce_bit.sv | 101 ++++++++++
 rtl/gpio_in_debounce.sv | 65 ++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared constants and types for the GPIO block family: default pin count,
// debounce counter width and synchroniser depth, plus the per-pin filter
// action encoding used by the debounce stage.
// -----------------------------------------------------------------------------
package gpio_pkg;

    localparam int GPIO_NUM_DEFAULT    = 16;
    localparam int GPIO_DBNC_CNT_WIDTH = 8;
    localparam int GPIO_SYNC_STAGES    = 2;

    // What the per-pin filter does on a given pclk edge.
    typedef enum logic [1:0] {
        FILT_IDLE   = 2'd0,  // synchronised input matches clean level: clear count
        FILT_COUNT  = 2'd1,  // mismatch, not yet stable long enough: keep counting
        FILT_UPDATE = 2'd2   // mismatch accepted: clean level follows input
    } filt_action_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_debounce_bit
// Single-pin input conditioner: SYNC_STAGES-deep synchroniser, stability
// counter, registered clean level and registered rise/fall pulses.
//
// Ports:
//   pclk            clock
//   preset_n        asynchronous active-low reset
//   filter_en       1 = debounce active, 0 = clean level follows synchroniser
//   debounce_cycles required stability count N (mismatch must last N+1 edges)
//   gpio_raw        asynchronous pad input
//   gpio_clean      filtered level
//   rise_pulse      one-cycle pulse on gpio_clean 0->1
//   fall_pulse      one-cycle pulse on gpio_clean 1->0
//   event_next      combinational: gpio_clean updates on the coming edge
//                   (lets the parent register its any_change in step with
//                   the pulses)
// -----------------------------------------------------------------------------
import gpio_pkg::*;

module gpio_debounce_bit #(
    parameter int CNT_WIDTH   = GPIO_DBNC_CNT_WIDTH,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic                 filter_en,
    input  logic [CNT_WIDTH-1:0] debounce_cycles,
    input  logic                 gpio_raw,
    output logic                 gpio_clean,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 event_next
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   clean_next;
    filt_action_e           action;

    // Plain flop chain; nothing may sit between stages or the metastability
    // settling time of each stage is eaten into.
    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the value from before this edge, not its neighbour's
    // freshly written one.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_raw};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Filter decision. The comparison against debounce_cycles uses the live
    // value, so lowering N mid-count lets a long-standing mismatch through on
    // the very next edge. cnt never passes N, so it cannot wrap.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        action     = FILT_IDLE;
        cnt_next   = '0;
        clean_next = gpio_clean;

        if (sync_s != gpio_clean) begin
            if (!filter_en || (cnt_q >= debounce_cycles)) begin
                action = FILT_UPDATE;
            end else begin
                action = FILT_COUNT;
            end
        end

        unique case (action)
            FILT_COUNT:  cnt_next   = cnt_q + CNT_WIDTH'(1);
            FILT_UPDATE: clean_next = sync_s;
            default:     cnt_next   = '0;
        endcase
    end

    assign event_next = (action == FILT_UPDATE);

    // Pulses are registered alongside the clean level, so they are high in
    // exactly the cycle the new level first appears.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q      <= '0;
            gpio_clean <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            cnt_q      <= cnt_next;
            gpio_clean <= clean_next;
            rise_pulse <= event_next &  sync_s;
            fall_pulse <= event_next & ~sync_s;
        end
    end

endmodule

// File: rtl/gpio_in_debounce.sv
// -----------------------------------------------------------------------------
// gpio_in_debounce
// Input-conditioning stage in front of the APB GPIO slave. Each pad input is
// synchronised into pclk and passed through a per-pin debounce filter; the
// clean levels feed the slave's gpio_in and the edge pulses feed event logic.
//
// Ports:
//   pclk            clock
//   preset_n        asynchronous active-low reset
//   filter_en       1 = debounce active, 0 = bypass filter (sync kept)
//   debounce_cycles required stability count N, shared by all pins
//   gpio_raw        asynchronous pad inputs
//   gpio_clean      filtered levels
//   rise_pulse      per-pin one-cycle pulse on clean 0->1
//   fall_pulse      per-pin one-cycle pulse on clean 1->0
//   any_change      registered OR of all pin events, aligned with the pulses
// -----------------------------------------------------------------------------
import gpio_pkg::*;

module gpio_in_debounce #(
    parameter int NUM_GPIOS   = GPIO_NUM_DEFAULT,
    parameter int CNT_WIDTH   = GPIO_DBNC_CNT_WIDTH,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic                 filter_en,
    input  logic [CNT_WIDTH-1:0] debounce_cycles,
    input  logic [NUM_GPIOS-1:0] gpio_raw,
    output logic [NUM_GPIOS-1:0] gpio_clean,
    output logic [NUM_GPIOS-1:0] rise_pulse,
    output logic [NUM_GPIOS-1:0] fall_pulse,
    output logic                 any_change
);

    logic [NUM_GPIOS-1:0] event_next;

    for (genvar i = 0; i < NUM_GPIOS; i++) begin : g_pin
        gpio_debounce_bit #(
            .CNT_WIDTH   (CNT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .pclk            (pclk),
            .preset_n        (preset_n),
            .filter_en       (filter_en),
            .debounce_cycles (debounce_cycles),
            .gpio_raw        (gpio_raw[i]),
            .gpio_clean      (gpio_clean[i]),
            .rise_pulse      (rise_pulse[i]),
            .fall_pulse      (fall_pulse[i]),
            .event_next      (event_next[i])
        );
    end

    // Registered from the pins' next-edge event flags rather than from the
    // pulse registers, so any_change lands in the same cycle as the pulses.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |event_next;
        end
    end

endmodule
